// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LS wins every tie.
module mem_port_arbiter #(
    parameter int unsigned ADDR  = 32,
    parameter int unsigned WORD  = 32,
    parameter int unsigned W_OPR = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic [WORD-1:0]  if_data_o,
    output logic             if_valid_o,
    output logic             if_stall_o,
    input  logic             ls_req_i,
    input  logic             ls_write_i,
    input  logic [ADDR-1:0]  ls_addr_i,
    input  logic [W_OPR-1:0] ls_data_i,
    output logic [W_OPR-1:0] ls_data_o,
    output logic             ls_valid_o,
    output logic             ls_stall_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic [W_OPR-1:0] mem_data_o,
    input  logic [W_OPR-1:0] mem_data_i,
    input  logic             mem_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             mem_req_d, mem_write_d;
    logic [ADDR-1:0]  mem_addr_d;
    logic [W_OPR-1:0] mem_data_d;
    logic [WORD-1:0]  if_data_d;
    logic [W_OPR-1:0] ls_data_d;
    logic             if_valid_d, ls_valid_d;
    logic             grant_ls;

    // Owner register doubles as the round-robin history (resets to IF).
`ifdef MEM_ARB_RR_EN
    assign grant_ls = ls_req_i & (~if_req_i | (owner_q == OWN_IF));
`else
    assign grant_ls = ls_req_i;
`endif

    assign if_stall_o = if_req_i & ~if_valid_o;
    assign ls_stall_o = ls_req_i & ~ls_valid_o;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_write_d = mem_write_o;
        mem_addr_d  = mem_addr_o;
        mem_data_d  = mem_data_o;
        if_data_d   = if_data_o;
        ls_data_d   = ls_data_o;
        case (state_q)
            IDLE: begin
                if (ls_req_i | if_req_i) begin
                    state_d = BUSY;
                    if (grant_ls) begin
                        owner_d     = OWN_LS;
                        mem_write_d = ls_write_i;
                        mem_addr_d  = ls_addr_i;
                        mem_data_d  = ls_data_i;
                    end else begin
                        owner_d     = OWN_IF;
                        mem_write_d = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_data_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (!mem_write_o) begin
                        if (owner_q == OWN_IF) if_data_d = mem_data_i[WORD-1:0];
                        else                   ls_data_d = mem_data_i;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_d  = (state_d == BUSY);
        if_valid_d = (state_d == DONE) && (owner_d == OWN_IF);
        ls_valid_d = (state_d == DONE) && (owner_d == OWN_LS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_o   <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            if_data_o   <= '0;
            ls_data_o   <= '0;
            if_valid_o  <= 1'b0;
            ls_valid_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_o   <= mem_req_d;
            mem_write_o <= mem_write_d;
            mem_addr_o  <= mem_addr_d;
            mem_data_o  <= mem_data_d;
            if_data_o   <= if_data_d;
            ls_data_o   <= ls_data_d;
            if_valid_o  <= if_valid_d;
            ls_valid_o  <= ls_valid_d;
        end
    end

endmodule
